// File: rtl/rice_residual_assembler_if.sv
// Handshake and data bundle between the Rice reader/predictor and the residual assembler.
interface rice_residual_assembler_if #(
  parameter int DATA_W = 32
);
  logic              enable;
  logic              start;
  logic [15:0]       partition_size;
  logic [15:0]       msb;
  logic [15:0]       lsb;
  logic [3:0]        rice_param;
  logic              done;
  logic [DATA_W-1:0] residual;
  logic              valid;
  logic              ready;
  logic              stall;
  logic              partition_done;
  logic              busy;
  logic              error;

  modport master (
    output enable, start, partition_size, msb, lsb, rice_param, done, ready,
    input  residual, valid, stall, partition_done, busy, error
  );

  modport slave (
    input  enable, start, partition_size, msb, lsb, rice_param, done, ready,
    output residual, valid, stall, partition_done, busy, error
  );
endinterface

// File: rtl/rice_residual_assembler.sv
// Rebuilds folded Rice values from (quotient, remainder) pairs, un-zigzags them to signed
// residuals and buffers them in a small FIFO, tracking partition progress.
module rice_residual_assembler #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  rice_residual_assembler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [15:0]       remaining_r;
  logic [DATA_W-1:0] s1_u_r;
  logic              s1_valid_r;
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              error_r;

  logic              accept_s;
  logic              bad_done_s;
  logic              rd_s;
  logic              wr_req_s;
  logic              wr_s;
  logic              full_s;
  logic              overflow_s;
  logic [AW+1:0]     occ_s;

  function automatic logic [DATA_W-1:0] fold(input logic [15:0] q, input logic [15:0] r,
                                             input logic [3:0] k);
    logic [DATA_W-1:0] mask;
    mask = (DATA_W'(1) << k) - DATA_W'(1);
    return (DATA_W'(q) << k) | (DATA_W'(r) & mask);
  endfunction

  function automatic logic [DATA_W-1:0] unzigzag(input logic [DATA_W-1:0] u);
    return (u >> 1) ^ {DATA_W{u[0]}};
  endfunction

  always_comb begin
    rd_s       = (count_r != '0) && bus.ready;
    full_s     = (count_r == (AW+1)'(FIFO_DEPTH));
    wr_req_s   = s1_valid_r && bus.enable;
    wr_s       = wr_req_s && (!full_s || rd_s);
    overflow_s = wr_req_s && full_s && !rd_s;
    accept_s   = bus.enable && bus.done && (state_r == RUN);
    bad_done_s = bus.enable && bus.done && ((state_r == IDLE) || (state_r == FLUSH));
    occ_s      = (AW+2)'(count_r) + (AW+2)'(s1_valid_r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Enable low freezes the sequencer in whatever state it holds.
  always_comb begin
    state_nxt_s = state_r;
    if (!bus.enable) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) state_nxt_s = (bus.partition_size == 16'd0) ? FLUSH : RUN;
          else           state_nxt_s = IDLE;
        end
        RUN: begin
          if (accept_s && (remaining_r == 16'd1)) state_nxt_s = FLUSH;
          else                                    state_nxt_s = RUN;
        end
        FLUSH: begin
          if (!s1_valid_r && (count_r == '0)) state_nxt_s = DONE;
          else                                state_nxt_s = FLUSH;
        end
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_r <= 16'd0;
    end else if (bus.enable && (state_r == IDLE) && bus.start) begin
      remaining_r <= bus.partition_size;
    end else if (accept_s) begin
      remaining_r <= remaining_r - 16'd1;
    end
  end

  // A pending stage-1 value is always written on the next enabled edge, so valid only persists on a new code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_u_r     <= '0;
      s1_valid_r <= 1'b0;
    end else if (bus.enable) begin
      s1_valid_r <= accept_s;
      if (accept_s) s1_u_r <= fold(bus.msb, bus.lsb, bus.rice_param);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= unzigzag(s1_u_r);
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (rd_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           error_r <= 1'b0;
    else if (bad_done_s || overflow_s) error_r <= 1'b1;
  end

  assign bus.residual       = mem_r[rd_ptr_r];
  assign bus.valid          = (count_r != '0);
  assign bus.stall          = (occ_s >= (AW+2)'(FIFO_DEPTH - 1)) || (state_r != RUN);
  assign bus.partition_done = (state_r == DONE);
  assign bus.busy           = (state_r != IDLE);
  assign bus.error          = error_r;
endmodule
